uart_rx_controller: RTL and testbench
=====================================

# uart_rx_controller

Frame sequencer for the UART receive path. Consumes the glitch-filtered serial line produced by the receive oversampling filter. Times start-bit validation, mid-bit sampling of data and stop bits, and assembles bytes LSB first. Presents each byte through a one-entry holding register with a valid/ack handshake, plus framing-error and overrun reporting.

## Interface
- CLK_PER_TICK, 1: clock cycles per oversample tick (≥1)
- OVERSAMPLE, 16: ticks per bit period (even, ≥4)
- DATA_BITS, 8: data bits per frame (1..8)

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; asynchronous, active-high
- RxD  input  1  filtered serial line, idle high
- data_ack  input  1  consumer has taken `data`; sampled on clk
- data  output  DATA_BITS  holding register, received byte
- data_valid  output  1  holding register full (level)
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- overrun  output  1  sticky; a byte was loaded while the previous one was unconsumed
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- Tick prescaler: counts 0..CLK_PER_TICK-1 and emits a tick on the terminal count. Cleared on entry to START. When CLK_PER_TICK=1, a tick occurs every cycle.
- Tick counter: reset to 0 on entry to START. Increments on each tick. Sample point k is the tick on which the counter reaches OVERSAMPLE/2 + k·OVERSAMPLE.
- IDLE: when RxD=0 is sampled, go to START.
- START, k=0:
  - RxD=0 → DATA, bit index 0.
  - RxD=1 → IDLE (false start). Nothing is reported.
- DATA, k=1..DATA_BITS: shift RxD into the shift register, LSB first. After bit DATA_BITS-1, go to STOP.
- STOP, k=DATA_BITS+1:
  - RxD=1 → load `data` from the shift register, set data_valid, go to IDLE.
  - RxD=0 → pulse frame_err, no load, go to WAIT_HIGH.
- WAIT_HIGH: stay until RxD=1 is sampled, then go to IDLE. This prevents a break condition from retriggering reception.
- Handshake:
  - data_valid clears on the cycle after data_ack is sampled high.
  - Load and ack in the same cycle: the load wins, data_valid stays 1, and overrun is not set.
  - Load while data_valid=1 and data_ack=0: data is overwritten with the new byte and overrun is set.
  - overrun clears only on reset.
  - data_ack while data_valid=0 has no effect.
- RxD changes between sample points are ignored. There is no majority vote here; filtering is upstream.

## Timing
- Reset values: IDLE, data=0, data_valid=0, frame_err=0, overrun=0, busy=0. All counters are cleared.
- Reset asserted mid-frame: the frame is aborted immediately. The partial byte is discarded and the holding register is cleared.
- Let c0 be the cycle at which IDLE samples RxD=0. START is entered at c0+1.
- Sample point k occurs at cycle c0 + CLK_PER_TICK·(OVERSAMPLE/2 + k·OVERSAMPLE).
- data_valid or frame_err becomes visible one cycle after the stop sample point.
  - Defaults: start check at c0+8, bit i at c0+8+16(i+1), stop at c0+152, data_valid high at c0+153.
- busy rises at c0+1. busy falls the cycle after the stop sample (good stop), or the cycle after RxD is seen high in WAIT_HIGH.
- Back-to-back frames: a start edge is detectable from the first cycle in IDLE after the stop sample, i.e. half a bit period before the nominal stop end. This gives up to +OVERSAMPLE/2 ticks of tolerance to transmitter slip.

## Test plan
- Byte 0xA5 at defaults, 16 cycles per bit, RxD low at c0 → data=0xA5 and data_valid=1 at c0+153. frame_err stays 0. data_ack at c0+160 → data_valid=0 at c0+161.
- False start: RxD low for 4 cycles, then high → START entered, returns to IDLE at c0+9. busy high c0+1..c0+8 only. No outputs change.
- Framing error: 0x3C with stop bit low, line held low 40 more cycles → frame_err pulses once at c0+153. data_valid stays 0. busy stays high until a cycle after RxD returns high. A subsequent 0x81 frame is received correctly.
- Overrun: 0x11 then 0x22 back-to-back with no ack → data=0x22, overrun=1. Repeat with data_ack asserted exactly on the second load cycle → data=0x22, data_valid=1, overrun=0.
- Reset mid-frame: rst pulsed at c0+60 during 0xFF → all outputs at reset values. A following 0x5A frame yields data=0x5A.
- CLK_PER_TICK=4, OVERSAMPLE=8, DATA_BITS=7, byte 0x55 → stop sample at c0+4·(4+64)=c0+272, data_valid at c0+273, data=0x55.

Source files
------------

// File: rtl/uart_rx_controller_if.sv
// Receive-side bundle for the UART frame sequencer.
// master = the sequencer, slave = line driver plus byte consumer.
interface uart_rx_controller_if #(
  parameter int DATA_BITS = 8
);
  logic                 RxD;
  logic                 data_ack;
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  RxD,
    input  data_ack,
    output data,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output RxD,
    output data_ack,
    input  data,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: start check, mid-bit sampling,
// LSB-first assembly, one-entry holding register with valid/ack.
module uart_rx_controller #(
  parameter int CLK_PER_TICK = 1,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_controller_if.master bus
);

  localparam int HALF = OVERSAMPLE / 2;
  localparam int TMAX = HALF + (DATA_BITS + 1) * OVERSAMPLE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state;
  state_t nstate;

  logic [PW-1:0]        presc;
  logic [TW-1:0]        tcnt;
  logic [TW-1:0]        tgt;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] sr;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  logic rx;
  logic tick;
  logic spt;
  logic go;
  logic count;
  logic shift;
  logic load;
  logic ferr;
  logic busy_c;

  assign rx   = bus.RxD;
  assign tick = (presc == PW'(CLK_PER_TICK - 1));
  // tgt holds the tick count of the next sample point
  assign spt  = tick && ((tcnt + TW'(1)) == tgt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (!rx) nstate = START;
      end
      START: begin
        if (spt) nstate = rx ? IDLE : DATA;
      end
      DATA: begin
        if (spt && bidx == BW'(DATA_BITS - 1))
          nstate = STOP;
      end
      STOP: begin
        if (spt) nstate = rx ? IDLE : WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (rx) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    go     = 1'b0;
    count  = 1'b0;
    shift  = 1'b0;
    load   = 1'b0;
    ferr   = 1'b0;
    busy_c = 1'b1;
    unique case (state)
      IDLE: begin
        go     = !rx;
        busy_c = 1'b0;
      end
      START: begin
        count = 1'b1;
      end
      DATA: begin
        count = 1'b1;
        shift = spt;
      end
      STOP: begin
        count = 1'b1;
        load  = spt && rx;
        ferr  = spt && !rx;
      end
      WAIT_HIGH: begin
        count = 1'b0;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tcnt  <= '0;
      tgt   <= '0;
      bidx  <= '0;
      sr    <= '0;
    end else if (go) begin
      presc <= '0;
      tcnt  <= '0;
      tgt   <= TW'(HALF);
      bidx  <= '0;
    end else if (count) begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) tcnt <= tcnt + TW'(1);
      if (spt) tgt <= tgt + TW'(OVERSAMPLE);
      if (shift) begin
        bidx <= bidx + BW'(1);
        sr   <= (sr >> 1)
              | (DATA_BITS'(rx) << (DATA_BITS - 1));
      end
    end
  end

  // a load beats a same-cycle ack, so the new byte is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= ferr;
      if (load) begin
        data_q  <= sr;
        valid_q <= 1'b1;
        if (valid_q && !bus.data_ack)
          ovr_q <= 1'b1;
      end else if (bus.data_ack) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: default build plus
// a CLK_PER_TICK=4 / OVERSAMPLE=8 / DATA_BITS=7 build.
module tb_uart_rx_controller;

  typedef struct {
    bit         fe;
    logic [7:0] d;
    int         c;
  } exp_t;

  localparam int P[2]  = '{16, 32};
  localparam int NB[2] = '{8, 7};
  localparam int T[2]  = '{8 + 9 * 16, 16 + 8 * 32};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd[2];
  logic ack[2];
  int   cyc  = 0;
  int   errs = 0;
  int   nchk = 0;
  bit   auto_ack = 1'b0;
  exp_t sbq0[$];
  exp_t sbq1[$];

  logic       dv[2];
  logic       fe[2];
  logic       ov[2];
  logic       by[2];
  logic [7:0] dat[2];
  logic       pdv[2];

  uart_rx_controller_if #(.DATA_BITS(8)) b0 ();
  uart_rx_controller_if #(.DATA_BITS(7)) b1 ();

  assign b0.RxD      = rxd[0];
  assign b0.data_ack = ack[0];
  assign b1.RxD      = rxd[1];
  assign b1.data_ack = ack[1];
  assign dv[0]  = b0.data_valid;
  assign dv[1]  = b1.data_valid;
  assign fe[0]  = b0.frame_err;
  assign fe[1]  = b1.frame_err;
  assign ov[0]  = b0.overrun;
  assign ov[1]  = b1.overrun;
  assign by[0]  = b0.busy;
  assign by[1]  = b1.busy;
  assign dat[0] = b0.data;
  assign dat[1] = {1'b0, b1.data};

  uart_rx_controller #(
    .CLK_PER_TICK(1), .OVERSAMPLE(16), .DATA_BITS(8)
  ) u0 (.clk(clk), .rst(rst), .bus(b0));

  uart_rx_controller #(
    .CLK_PER_TICK(4), .OVERSAMPLE(8), .DATA_BITS(7)
  ) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one frame; expected result is pushed when the start edge goes out
  task automatic send(input int u, input logic [7:0] b, input bit good,
                      input int extra, input bit gl, input bit push);
    logic v;
    exp_t e;
    for (int s = 0; s < NB[u] + 2; s++) begin
      if (s == 0) v = 1'b0;
      else if (s == NB[u] + 1) v = good;
      else v = b[s-1];
      for (int j = 0; j < P[u]; j++) begin
        rxd[u] = (gl && j == 2) ? ~v : v;
        if (s == 0 && j == 0 && push) begin
          e.fe = !good;
          e.d  = good ? (b & ((u == 1) ? 8'h7f : 8'hff)) : 8'h00;
          e.c  = cyc + 1 + T[u];
          if (u == 0) sbq0.push_back(e);
          else sbq1.push_back(e);
        end
        @(negedge clk);
      end
    end
    if (!good) begin
      rxd[u] = 1'b0;
      repeat (extra) @(negedge clk);
    end
    rxd[u] = 1'b1;
  endtask

  task automatic idle(input int u, input int n);
    rxd[u] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic consumer(input int u);
    forever begin
      @(negedge clk);
      if (auto_ack && dv[u] && !rst) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        if (auto_ack && !rst) begin
          ack[u] = 1'b1;
          @(negedge clk);
          ack[u] = 1'b0;
          chk($sformatf("ack_clears_u%0d", u), dv[u], 0);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        pdv[u] = 1'b0;
      end else begin
        if ((dv[u] && !pdv[u]) || fe[u]) begin
          have = (u == 0) ? (sbq0.size() > 0) : (sbq1.size() > 0);
          if (!have) begin
            nchk++;
            errs++;
            $display("FAIL sb_unexpected_u%0d: dv=%0b fe=%0b data=%0h, none expected",
                     u, dv[u], fe[u], dat[u]);
          end else begin
            e = (u == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk($sformatf("sb_ferr_u%0d", u), fe[u], e.fe);
            if (!e.fe) chk($sformatf("sb_data_u%0d", u), dat[u], e.d);
            chk($sformatf("sb_time_u%0d", u), cyc, e.c);
          end
        end
        pdv[u] = dv[u];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         good;
    rxd = '{1'b1, 1'b1};
    ack = '{1'b0, 1'b0};
    fork
      consumer(0);
      consumer(1);
    join_none
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_data", dat[u], 0);
      chk("rst_valid", dv[u], 0);
      chk("rst_ferr", fe[u], 0);
      chk("rst_ovr", ov[u], 0);
      chk("rst_busy", by[u], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    auto_ack = 1'b1;

    send(0, 8'hA5, 1, 0, 0, 1);
    idle(0, 30);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("idle_ack_valid", dv[0], 0);
    chk("idle_ack_ovr", ov[0], 0);

    rxd[0] = 1'b0;
    for (int m = 0; m < 12; m++) begin
      @(negedge clk);
      chk($sformatf("false_start_busy_%0d", m), by[0], (m < 8));
      if (m == 3) rxd[0] = 1'b1;
    end
    idle(0, 5);

    send(0, 8'h3C, 0, 40, 0, 1);
    chk("ferr_busy_held", by[0], 1);
    @(negedge clk);
    chk("ferr_busy_drop", by[0], 0);
    idle(0, 3);
    send(0, 8'h81, 1, 0, 0, 1);
    idle(0, 30);

    auto_ack = 1'b0;
    send(0, 8'h11, 1, 0, 0, 1);
    send(0, 8'h22, 1, 0, 0, 0);
    idle(0, 4);
    chk("ovr_data", dat[0], 8'h22);
    chk("ovr_flag", ov[0], 1);
    chk("ovr_valid", dv[0], 1);
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    chk("ovr_ack_valid", dv[0], 0);
    chk("ovr_sticky", ov[0], 1);
    rst = 1'b1;
    @(negedge clk);
    chk("ovr_rst_flag", ov[0], 0);
    rst = 1'b0;
    @(negedge clk);

    send(0, 8'h11, 1, 0, 0, 1);
    fork
      send(0, 8'h22, 1, 0, 0, 0);
      begin
        repeat (T[0]) @(negedge clk);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
      end
    join
    idle(0, 2);
    chk("ackload_data", dat[0], 8'h22);
    chk("ackload_valid", dv[0], 1);
    chk("ackload_ovr", ov[0], 0);

    fork
      send(0, 8'hFF, 1, 0, 0, 0);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_data", dat[0], 0);
        chk("midrst_valid", dv[0], 0);
        chk("midrst_busy", by[0], 0);
        chk("midrst_ovr", ov[0], 0);
        chk("midrst_ferr", fe[0], 0);
        @(negedge clk);
        rst = 1'b0;
      end
    join
    idle(0, 5);
    auto_ack = 1'b1;
    send(0, 8'h5A, 1, 0, 0, 1);
    idle(0, 30);

    for (int i = 0; i < 16; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send(0, b, good, $urandom_range(0, 30), 1'($urandom_range(0, 1)), 1);
      idle(0, good ? $urandom_range(0, 3) : $urandom_range(2, 6));
    end
    idle(0, 30);

    send(1, 8'h55, 1, 0, 0, 1);
    idle(1, 10);
    for (int i = 0; i < 6; i++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      send(1, b, good, $urandom_range(0, 40), 1'($urandom_range(0, 1)), 1);
      idle(1, good ? $urandom_range(0, 3) : $urandom_range(2, 6));
    end
    idle(1, 60);

    chk("sb_drain_u0", sbq0.size(), 0);
    chk("sb_drain_u1", sbq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
